// File: rtl/ahb_lite_imem_slave.sv
// AHB-Lite word-addressed instruction memory with programmable NONSEQ/SEQ wait states,
// optional bus writes, a preload side port and two-cycle ERROR responses.
//
// state  | meaning
// S_IDLE | no data phase in progress, zero-wait OKAY
// S_WAIT | legal transfer accepted, counting down wait states
// S_DATA | final data-phase cycle, read data driven / write committed
// S_ERR1 | first ERROR cycle (HREADYOUT low)
// S_ERR2 | second ERROR cycle (HREADYOUT high)
module ahb_lite_imem_slave #(
  parameter int DEPTH    = 256,
  parameter int WAIT_NS  = 2,
  parameter int WAIT_SEQ = 0,
  parameter int WRITE_EN = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic [3:0]               HBURST,
  input  logic [2:0]               HSIZE,
  input  logic                     HWRITE,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [AW-1:0]   r_idx;
  logic            r_write;
  logic            r_legal;
  logic [31:0]     r_hold;
  logic [31:0]     r_mem [DEPTH];

  logic            w_ready;
  logic            w_accept;
  logic            w_illegal;
  logic [3:0]      w_wait;
  logic            w_rd;
  logic            w_bus_we;
  logic            w_unused;

  assign w_ready   = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept  = HSEL && HREADY && HTRANS[1] && w_ready;
  assign w_illegal = ({1'b0, HADDR} >= SPAN) || (HADDR[1:0] != 2'b00) ||
                     (HSIZE != 3'b010) || (HWRITE && (WRITE_EN == 0));
  assign w_wait    = HTRANS[0] ? 4'(WAIT_SEQ) : 4'(WAIT_NS);
  assign w_rd      = (r_state == S_DATA) && !r_write;
  assign w_bus_we  = (r_state == S_DATA) && r_write && r_legal;
  assign w_unused  = ^HBURST;

  assign HREADYOUT = w_ready;
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  // Read data is combinational so a read right after a write sees the new word.
  assign HRDATA    = w_rd ? r_mem[r_idx] : r_hold;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_DATA;
        end
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_state_nxt = S_ERR1;
          end else if (w_wait != 4'd0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_wait;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_legal <= 1'b0;
      r_hold  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= HADDR[AW+1:2];
        r_write <= HWRITE;
        r_legal <= !w_illegal;
      end
      if (w_rd) begin
        r_hold <= r_mem[r_idx];
      end
    end
  end

  // Preload is written last so it wins over a bus write to the same word.
  always_ff @(posedge HCLK) begin
    if (w_bus_we) begin
      r_mem[r_idx] <= HWDATA;
    end
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_ahb_lite_imem_slave.sv
// Bench for ahb_lite_imem_slave: two instances (writable / read-only with different waits),
// a table of single transfers, hand-written pipelined sequences and random traffic vs a word-level model.
module tb_ahb_lite_imem_slave;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef struct {
    bit            sel;
    bit [1:0]      trans;
    bit [31:0]     addr;
    bit            wr;
    bit [2:0]      size;
    bit [31:0]     wdata;
    bit            ld;
    bit [AW-1:0]   ld_idx;
    bit [31:0]     ld_data;
  } beat_t;

  typedef struct {
    int        cycles;
    bit        resp;
    bit [31:0] rdata;
  } res_t;

  typedef struct {
    int          t;
    logic [1:0]  tr;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          e_cyc;
    logic        e_resp;
    logic        chk_d;
    logic [31:0] e_data;
  } vec_t;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [1:0]    sel_v;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic [3:0]    HBURST;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [1:0]    load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [31:0]   rdata0, rdata1;
  logic [1:0]    rdy, resp;
  int            tgt = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = (tgt == 1) ? rdy[1] : rdy[0];

  ahb_lite_imem_slave #(.DEPTH(DEPTH), .WAIT_NS(2), .WAIT_SEQ(0), .WRITE_EN(1)) u_rw (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel_v[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(rdata0), .HREADYOUT(rdy[0]), .HRESP(resp[0]),
    .load_en(load_en[0]), .load_addr(load_addr), .load_data(load_data));

  ahb_lite_imem_slave #(.DEPTH(DEPTH), .WAIT_NS(1), .WAIT_SEQ(3), .WRITE_EN(0)) u_ro (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel_v[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(rdata1), .HREADYOUT(rdy[1]), .HRESP(resp[1]),
    .load_en(load_en[1]), .load_addr(load_addr), .load_data(load_data));

  int p_ns[2] = '{2, 1};
  int p_sq[2] = '{0, 3};
  int p_we[2] = '{1, 0};

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] hold_m [2];
  beat_t       q[$];
  res_t        rq[$];
  beat_t       cur, idle_b;
  bit          dp_act, dp_err, dp_wr;
  bit [AW-1:0] dp_idx;
  bit [31:0]   dp_wdata;
  int          dp_left, dp_cyc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input bit s, input bit [1:0] tr, input bit [31:0] a,
                               input bit w, input bit [31:0] wd);
    beat_t b;
    b.sel = s; b.trans = tr; b.addr = a; b.wr = w; b.size = 3'd2; b.wdata = wd;
    b.ld = 1'b0; b.ld_idx = '0; b.ld_data = 32'd0;
    return b;
  endfunction

  function automatic beat_t ldb(input bit [AW-1:0] idx, input bit [31:0] d);
    beat_t b;
    b = mk(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    b.ld = 1'b1; b.ld_idx = idx; b.ld_data = d;
    return b;
  endfunction

  task automatic drive_cur();
    sel_v  = cur.sel ? ((tgt == 1) ? 2'b10 : 2'b01) : 2'b00;
    HADDR  = cur.addr;
    HTRANS = cur.trans;
    HWRITE = cur.wr;
    HSIZE  = cur.size;
    HBURST = cur.trans[0] ? 4'b0011 : 4'b0001;
  endtask

  // One bus cycle: compare against the model, then present the next address phase.
  task automatic step();
    logic a_rdy, a_resp, e_rdy, e_resp;
    logic [31:0] a_rd, e_rd;
    @(negedge HCLK);
    a_rdy  = rdy[tgt];
    a_resp = resp[tgt];
    a_rd   = (tgt == 1) ? rdata1 : rdata0;
    if (!dp_act)     e_rdy = 1'b1;
    else if (dp_err) e_rdy = (dp_cyc == 2);
    else             e_rdy = (dp_left == 0);
    e_resp = dp_act && dp_err;
    e_rd   = (dp_act && !dp_err && !dp_wr && e_rdy) ? mem_m[tgt][dp_idx] : hold_m[tgt];
    chk("hreadyout", 32'(a_rdy), 32'(e_rdy));
    chk("hresp", 32'(a_resp), 32'(e_resp));
    chk("hrdata", a_rd, e_rd);
    HWDATA  = (dp_act && dp_wr) ? dp_wdata : $urandom;
    load_en = 2'b00;
    if (e_rdy) begin
      if (dp_act) begin
        if (!dp_err) begin
          if (dp_wr) mem_m[tgt][dp_idx] = dp_wdata;
          else       hold_m[tgt] = mem_m[tgt][dp_idx];
        end
        rq.push_back('{dp_cyc, a_resp, a_rd});
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idle_b;
      if (cur.ld) begin
        load_en[tgt] = 1'b1;
        load_addr    = cur.ld_idx;
        load_data    = cur.ld_data;
        mem_m[tgt][cur.ld_idx] = cur.ld_data;
      end
      dp_act = cur.sel && cur.trans[1];
      if (dp_act) begin
        dp_cyc   = 1;
        dp_wr    = cur.wr;
        dp_idx   = cur.addr[AW+1:2];
        dp_wdata = cur.wdata;
        dp_err   = (cur.addr >= 32'(DEPTH * 4)) || (cur.addr[1:0] != 2'b00) ||
                   (cur.size != 3'd2) || (cur.wr && (p_we[tgt] == 0));
        dp_left  = cur.trans[0] ? p_sq[tgt] : p_ns[tgt];
      end
      drive_cur();
    end else begin
      dp_cyc++;
      if (!dp_err) dp_left--;
    end
  endtask

  task automatic run_all();
    int guard = 0;
    while ((q.size() > 0 || dp_act) && guard < 3000) begin
      step();
      guard++;
    end
    chk("run_within_budget", 32'(guard < 3000), 32'd1);
    q.delete();
    step();
    step();
  endtask

  task automatic exp_res(input string nm, input int cyc, input logic rs, input logic cd,
                         input logic [31:0] d);
    res_t r;
    chk({nm, "_present"}, 32'(rq.size() > 0), 32'd1);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk({nm, "_cycles"}, 32'(r.cycles), 32'(cyc));
      chk({nm, "_resp"}, 32'(r.resp), 32'(rs));
      if (cd) chk({nm, "_data"}, r.rdata, d);
    end
  endtask

  task automatic preload(input int t, input int idx, input logic [31:0] d);
    @(negedge HCLK);
    load_en   = (t == 1) ? 2'b10 : 2'b01;
    load_addr = AW'(idx);
    load_data = d;
    mem_m[t][idx] = d;
    @(negedge HCLK);
    load_en = 2'b00;
  endtask

  task automatic do_reset();
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_hreadyout", 32'(rdy[0]), 32'd1);
    chk("rst_mid_hresp", 32'(resp[0]), 32'd0);
    chk("rst_mid_hrdata", rdata0, 32'd0);
    dp_act = 1'b0;
    cur = idle_b;
    hold_m[0] = 32'd0;
    hold_m[1] = 32'd0;
    load_en = 2'b00;
    drive_cur();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    int r;
    b = mk($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 32'd0,
           1'($urandom_range(0, 1)), $urandom);
    r = $urandom_range(0, 9);
    if (r < 7)       b.addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (r == 7) b.addr = $urandom;
    else if (r == 8) b.addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else             b.addr = 32'h400 + 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 9) == 0) b.size = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) begin
      b.ld = 1'b1; b.ld_idx = AW'($urandom_range(0, 255)); b.ld_data = $urandom;
    end
    return b;
  endfunction

  vec_t tbl[12];
  logic [31:0] oldv;

  initial begin
    tbl[0]  = '{0, 2'b10, 32'h14,       1'b0, 3'd2, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{0, 2'b10, 32'h402,      1'b0, 3'd2, 32'h0,        2, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{0, 2'b10, 32'h400,      1'b0, 3'd2, 32'h0,        2, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{0, 2'b10, 32'h14,       1'b0, 3'd1, 32'h0,        2, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{0, 2'b10, 32'h08,       1'b1, 3'd2, 32'hCAFEF00D, 3, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{0, 2'b10, 32'h08,       1'b0, 3'd2, 32'h0,        3, 1'b0, 1'b1, 32'hCAFEF00D};
    tbl[6]  = '{0, 2'b11, 32'h14,       1'b0, 3'd2, 32'h0,        1, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[7]  = '{1, 2'b10, 32'h08,       1'b1, 3'd2, 32'h0BADF00D, 2, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1, 2'b10, 32'h08,       1'b0, 3'd2, 32'h0,        2, 1'b0, 1'b1, 32'h22222222};
    tbl[9]  = '{1, 2'b11, 32'h14,       1'b0, 3'd2, 32'h0,        4, 1'b0, 1'b1, 32'h55550005};
    tbl[10] = '{0, 2'b10, 32'h3FC,      1'b0, 3'd2, 32'h0,        3, 1'b0, 1'b1, 32'hFFFF00FF};
    tbl[11] = '{0, 2'b10, 32'hFFFFFFFC, 1'b0, 3'd2, 32'h0,        2, 1'b1, 1'b0, 32'h0};

    idle_b = mk(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    cur = idle_b;
    dp_act = 1'b0;
    hold_m[0] = 32'd0;
    hold_m[1] = 32'd0;
    HRESETn = 1'b0;
    load_en = 2'b00; load_addr = '0; load_data = 32'd0;
    HWDATA = 32'd0;
    drive_cur();
    #1;
    chk("reset_hreadyout", {30'd0, rdy}, 32'd3);
    chk("reset_hresp", {30'd0, resp}, 32'd0);
    chk("reset_hrdata_rw", rdata0, 32'd0);
    chk("reset_hrdata_ro", rdata1, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge HCLK);
      load_en = 2'b11; load_addr = AW'(i); load_data = $urandom;
      mem_m[0][i] = load_data;
      mem_m[1][i] = load_data;
    end
    @(negedge HCLK);
    load_en = 2'b00;
    preload(0, 5, 32'hDEADBEEF);
    for (int i = 16; i < 20; i++) preload(0, i, 32'h16000000 | 32'(i));
    preload(0, 255, 32'hFFFF00FF);
    preload(1, 5, 32'h55550005);
    preload(1, 2, 32'h22222222);

    for (int i = 0; i < 12; i++) begin
      beat_t b;
      b = mk(1'b1, tbl[i].tr, tbl[i].addr, tbl[i].wr, tbl[i].wd);
      b.size = tbl[i].sz;
      tgt = tbl[i].t;
      rq.delete();
      q.push_back(b);
      run_all();
      exp_res($sformatf("tbl%0d", i), tbl[i].e_cyc, tbl[i].e_resp, tbl[i].chk_d, tbl[i].e_data);
    end

    tgt = 0;
    rq.delete();
    q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b0, 32'd0));
    for (int i = 1; i < 4; i++) q.push_back(mk(1'b1, 2'b11, 32'h40 + 32'(i * 4), 1'b0, 32'd0));
    run_all();
    exp_res("incr4_b0", 3, 1'b0, 1'b1, 32'h16000010);
    exp_res("incr4_b1", 1, 1'b0, 1'b1, 32'h16000011);
    exp_res("incr4_b2", 1, 1'b0, 1'b1, 32'h16000012);
    exp_res("incr4_b3", 1, 1'b0, 1'b1, 32'h16000013);

    rq.delete();
    q.push_back(mk(1'b1, 2'b10, 32'h0C, 1'b1, 32'h12345678));
    q.push_back(mk(1'b1, 2'b10, 32'h0C, 1'b0, 32'd0));
    q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 32'hA5A55A5A));
    q.push_back(mk(1'b1, 2'b11, 32'h10, 1'b0, 32'd0));
    run_all();
    exp_res("b2b_wr", 3, 1'b0, 1'b0, 32'd0);
    exp_res("b2b_rd", 3, 1'b0, 1'b1, 32'h12345678);
    exp_res("raw_wr", 3, 1'b0, 1'b0, 32'd0);
    exp_res("raw_seq_rd", 1, 1'b0, 1'b1, 32'hA5A55A5A);

    rq.delete();
    q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b0, 32'd0));
    q.push_back(mk(1'b1, 2'b01, 32'h44, 1'b0, 32'd0));
    q.push_back(mk(1'b1, 2'b11, 32'h44, 1'b0, 32'd0));
    q.push_back(mk(1'b0, 2'b10, 32'h14, 1'b1, 32'h0));
    q.push_back(mk(1'b1, 2'b10, 32'h14, 1'b0, 32'd0));
    run_all();
    exp_res("busy_b0", 3, 1'b0, 1'b1, 32'h16000010);
    exp_res("busy_b1", 1, 1'b0, 1'b1, 32'h16000011);
    exp_res("unsel_untouched", 3, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("busy_no_extra", 32'(rq.size()), 32'd0);

    rq.delete();
    oldv = mem_m[0][9];
    q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b1, 32'h11111111));
    q.push_back(ldb(8'd8, 32'h22222222));
    q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b0, 32'd0));
    q.push_back(mk(1'b1, 2'b10, 32'h24, 1'b0, 32'd0));
    q.push_back(ldb(8'd9, 32'h33333333));
    q.push_back(mk(1'b1, 2'b10, 32'h24, 1'b0, 32'd0));
    run_all();
    exp_res("coll_wr", 3, 1'b0, 1'b0, 32'd0);
    exp_res("coll_wr_dropped", 3, 1'b0, 1'b1, 32'h22222222);
    exp_res("coll_rd_old", 3, 1'b0, 1'b1, oldv);
    exp_res("coll_rd_new", 3, 1'b0, 1'b1, 32'h33333333);

    rq.delete();
    q.push_back(mk(1'b1, 2'b10, 32'h14, 1'b0, 32'd0));
    step();
    step();
    do_reset();
    rq.delete();
    q.push_back(mk(1'b1, 2'b10, 32'h14, 1'b0, 32'd0));
    run_all();
    exp_res("after_reset", 3, 1'b0, 1'b1, 32'hDEADBEEF);

    for (int t = 0; t < 2; t++) begin
      tgt = t;
      for (int n = 0; n < 150; n++) q.push_back(rand_beat());
      run_all();
    end
    rq.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
